// File: rtl/reg_dump_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : reg_dump_pkg
//  Description : Shared constants, FSM state type and select-wrap helper for
//                the register dump reader.
//  Revision    : 1.0 - initial release
// ============================================================================
package reg_dump_pkg;

    localparam int c_num_regs_default   = 32;
    localparam int c_data_width_default = 32;
    localparam int c_sel_width          = 5;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_READ   = 2'd1,
        ST_SEND   = 2'd2,
        ST_FINISH = 2'd3
    } dump_state_t;

    // Advance a register select, wrapping from the top register back to 0.
    function automatic logic [c_sel_width-1:0] next_sel(
        input logic [c_sel_width-1:0] sel,
        input int                     num_regs
    );
        if (int'(sel) == num_regs - 1) begin
            return '0;
        end
        return sel + 1'b1;
    endfunction

endpackage
`default_nettype wire

// File: rtl/reg_dump_reader.sv
`default_nettype none
// ============================================================================
//  Module      : reg_dump_reader
//  Description : Walks a range of a combinational-read register file and
//                streams each (index, value) pair out over a valid/ready
//                handshake. Ranges with first > last wrap through index 0.
//  Revision    : 1.0 - initial release
// ============================================================================
module reg_dump_reader
    import reg_dump_pkg::*;
#(
    parameter int NUM_REGS   = c_num_regs_default,
    parameter int DATA_WIDTH = c_data_width_default
) (
    input  logic                   clock,
    input  logic                   reset,
    input  logic                   start,
    input  logic [c_sel_width-1:0] first_sel,
    input  logic [c_sel_width-1:0] last_sel,
    output logic [c_sel_width-1:0] rf_sel,
    input  logic [DATA_WIDTH-1:0]  rf_data,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic [c_sel_width-1:0] out_index,
    output logic [DATA_WIDTH-1:0]  out_data,
    output logic                   busy,
    output logic                   done
);

    dump_state_t              r_state;
    dump_state_t              w_state_next;

    logic [c_sel_width-1:0]   r_sel;
    logic [c_sel_width-1:0]   r_last;
    logic                     r_out_valid;
    logic [c_sel_width-1:0]   r_out_index;
    logic [DATA_WIDTH-1:0]    r_out_data;

    logic                     w_load;
    logic                     w_capture;
    logic                     w_xfer;
    logic                     w_is_last;

    // State register; reset aborts any dump in progress without a done pulse.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Next-state decode plus the strobes that steer the datapath registers.
    always_comb begin
        w_state_next = r_state;
        w_load       = 1'b0;
        w_capture    = 1'b0;
        w_xfer       = 1'b0;
        w_is_last    = (r_out_index == r_last);
        case (r_state)
            ST_IDLE: begin
                // start is only honoured here, so a start while busy can
                // never disturb the latched range.
                if (start) begin
                    w_load       = 1'b1;
                    w_state_next = ST_READ;
                end
            end
            ST_READ: begin
                w_capture    = 1'b1;
                w_state_next = ST_SEND;
            end
            ST_SEND: begin
                if (r_out_valid && out_ready) begin
                    w_xfer       = 1'b1;
                    w_state_next = w_is_last ? ST_FINISH : ST_READ;
                end
            end
            ST_FINISH: begin
                w_state_next = ST_IDLE;
            end
            default: begin
                w_state_next = ST_IDLE;
            end
        endcase
    end

    // Range latch, read select walk and output word capture.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_sel       <= '0;
            r_last      <= '0;
            r_out_valid <= 1'b0;
            r_out_index <= '0;
            r_out_data  <= '0;
        end else begin
            if (w_load) begin
                r_sel  <= first_sel;
                r_last <= last_sel;
            end
            if (w_capture) begin
                r_out_data  <= rf_data;
                r_out_index <= r_sel;
                r_out_valid <= 1'b1;
            end
            if (w_xfer) begin
                r_out_valid <= 1'b0;
                // Leave the select on the final index once the range is done.
                if (!w_is_last) begin
                    r_sel <= next_sel(r_sel, NUM_REGS);
                end
            end
        end
    end

    assign rf_sel    = r_sel;
    assign out_valid = r_out_valid;
    assign out_index = r_out_index;
    assign out_data  = r_out_data;
    assign busy      = (r_state != ST_IDLE);
    assign done      = (r_state == ST_FINISH);

endmodule
`default_nettype wire
